// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access stage: DMType codes, FSM
// state encoding, byte-enable constants and the alignment check used on the
// live MEM-stage request.
package dm_pkg;

  typedef enum logic [2:0] {
    DM_WORD   = 3'b000,
    DM_HALF   = 3'b001,
    DM_HALF_U = 3'b010,
    DM_BYTE   = 3'b011,
    DM_BYTE_U = 3'b100
  } dmtype_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  // Unknown DMType codes fall into the word case.
  function automatic logic dm_aligned(input logic [2:0] dmtype,
                                      input logic [1:0] addr_lo);
    case (dmtype)
      DM_HALF, DM_HALF_U: return ~addr_lo[0];
      DM_BYTE, DM_BYTE_U: return 1'b1;
      default:            return (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// Combinational lane formatter.
//   dmtype   : access type (dm_pkg encoding)
//   addr_lo  : byte offset within the word
//   st_wdata : right-aligned store data   -> st_data (lane-replicated), st_be
//   ld_raw   : raw memory word            -> ld_data (extracted, extended)
module dm_lane_fmt
  import dm_pkg::*;
(
  input  logic [2:0]  dmtype,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_data,
  output logic [3:0]  st_be,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = ld_raw >> {addr_lo, 3'b000};
    st_data = st_wdata;
    st_be   = BE_WORD;
    ld_data = shifted;
    case (dmtype)
      DM_HALF, DM_HALF_U: begin
        st_data = {2{st_wdata[15:0]}};
        st_be   = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        ld_data = (dmtype == DM_HALF) ? {{16{shifted[15]}}, shifted[15:0]}
                                      : {16'h0000, shifted[15:0]};
      end
      DM_BYTE, DM_BYTE_U: begin
        st_data = {4{st_wdata[7:0]}};
        st_be   = BE_BYTE0 << addr_lo;
        ld_data = (dmtype == DM_BYTE) ? {{24{shifted[7]}}, shifted[7:0]}
                                      : {24'h000000, shifted[7:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory access stage between the CPU MEM stage and a variable-latency
// req/gnt/rvalid memory port.
//   clk, rst (sync, active-low)
//   cpu_*  : MEM-stage request in; formatted load data, stall, misalign and
//            bus-error pulses out
//   mem_*  : word-aligned request, byte enables, replicated store data out;
//            gnt, rvalid and raw read data in
module dm_access_unit
  import dm_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_dmtype,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_misalign,
  output logic        cpu_buserr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       dmtype_q, dmtype_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             buserr_q, buserr_d;

  logic             stall, misalign, timeout, in_req;
  logic [31:0]      st_data, ld_data;
  logic [3:0]       st_be;

  dm_lane_fmt u_fmt (
    .dmtype   (dmtype_q),
    .addr_lo  (addr_q[1:0]),
    .st_wdata (wdata_q),
    .st_data  (st_data),
    .st_be    (st_be),
    .ld_raw   (mem_rdata),
    .ld_data  (ld_data)
  );

  // >= rather than ==: a gnt that wins the race at the limit moves to WAIT
  // with the budget already spent, so WAIT must still be able to time out.
  assign timeout = (cnt_q >= CNT_W'(WAIT_MAX - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dmtype_d = dmtype_q;
    rdata_d  = rdata_q;
    buserr_d = 1'b0;
    stall    = 1'b0;
    misalign = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cpu_req) begin
          if (dm_aligned(cpu_dmtype, cpu_addr[1:0])) begin
            we_d     = cpu_we;
            addr_d   = cpu_addr;
            wdata_d  = cpu_wdata;
            dmtype_d = cpu_dmtype;
            stall    = 1'b1;
            state_d  = S_REQ;
          end else begin
            misalign = 1'b1;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_gnt) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (timeout) begin
          buserr_d = 1'b1;
          if (!we_q) rdata_d = '0;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rvalid) begin
          rdata_d = ld_data;
          state_d = S_DONE;
        end else if (timeout) begin
          buserr_d = 1'b1;
          rdata_d  = '0;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      dmtype_q <= '0;
      rdata_q  <= '0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dmtype_q <= dmtype_d;
      rdata_q  <= rdata_d;
      buserr_q <= buserr_d;
    end
  end

  // Combinational pulses are masked while reset is asserted so every output
  // reads 0 during reset.
  assign cpu_stall    = stall & rst;
  assign cpu_misalign = misalign & rst;
  assign cpu_buserr   = buserr_q;
  assign cpu_rdata    = rdata_q;

  assign in_req    = (state_q == S_REQ);
  assign mem_req   = in_req;
  assign mem_we    = in_req & we_q;
  assign mem_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_be    = in_req ? (we_q ? st_be : BE_WORD) : '0;
  assign mem_wdata = in_req ? st_data : '0;

endmodule

// File: tb/tb_dm_access_unit.sv
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_dmtype;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_misalign, cpu_buserr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  dm_access_unit #(.WAIT_MAX(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_dmtype(cpu_dmtype),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cpu_misalign(cpu_misalign), .cpu_buserr(cpu_buserr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_dmtype = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    tests++; if (cpu_rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata got=%h exp=0", cpu_rdata); end
    tests++; if ({cpu_stall, cpu_misalign, cpu_buserr} !== 3'b000) begin fails++; $display("FAIL rst_cpu_flags got=%b exp=000", {cpu_stall, cpu_misalign, cpu_buserr}); end
    tests++; if ({mem_req, mem_we, mem_be} !== 6'b0) begin fails++; $display("FAIL rst_mem_ctl got=%b exp=0", {mem_req, mem_we, mem_be}); end
    tests++; if ({mem_addr, mem_wdata} !== 64'h0) begin fails++; $display("FAIL rst_mem_data got=%h exp=0", {mem_addr, mem_wdata}); end
    tick();
  endtask

  task automatic test_store_byte();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1003; cpu_wdata = 32'hA5; cpu_dmtype = 3'b011;
    #1;
    tests++; if ({cpu_stall, mem_req} !== 2'b10) begin fails++; $display("FAIL sb_c1 stall,req got=%b exp=10", {cpu_stall, mem_req}); end
    tick();
    mem_gnt = 1'b1;
    #1;
    tests++; if ({cpu_stall, mem_req, mem_we} !== 3'b111) begin fails++; $display("FAIL sb_c2 stall,req,we got=%b exp=111", {cpu_stall, mem_req, mem_we}); end
    tests++; if (mem_addr !== 32'h1000) begin fails++; $display("FAIL sb_addr got=%h exp=00001000", mem_addr); end
    tests++; if (mem_be !== 4'b1000) begin fails++; $display("FAIL sb_be got=%b exp=1000", mem_be); end
    tests++; if (mem_wdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", mem_wdata); end
    tick();
    mem_gnt = 1'b0; cpu_req = 1'b0;
    #1;
    tests++; if ({cpu_stall, mem_req, cpu_buserr} !== 3'b000) begin fails++; $display("FAIL sb_c3 stall,req,buserr got=%b exp=000", {cpu_stall, mem_req, cpu_buserr}); end
    tick();
  endtask

  task automatic test_store_half();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h6002; cpu_wdata = 32'hDEADBEEF; cpu_dmtype = 3'b001;
    #1;
    tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL sh_c1_stall got=%b exp=1", cpu_stall); end
    tick();
    #1;
    tests++; if ({mem_req, mem_be, mem_wdata} !== {1'b1, 4'b1100, 32'hBEEFBEEF}) begin fails++; $display("FAIL sh_c2 req,be,wdata got=%h exp=%h", {mem_req, mem_be, mem_wdata}, {1'b1, 4'b1100, 32'hBEEFBEEF}); end
    tick();
    mem_gnt = 1'b1;
    #1;
    tests++; if ({cpu_stall, mem_req} !== 2'b11) begin fails++; $display("FAIL sh_c3 stall,req got=%b exp=11", {cpu_stall, mem_req}); end
    tick();
    mem_gnt = 1'b0; cpu_req = 1'b0;
    #1;
    tests++; if ({cpu_stall, mem_req} !== 2'b00) begin fails++; $display("FAIL sh_done stall,req got=%b exp=00", {cpu_stall, mem_req}); end
    tick();
  endtask

  task automatic test_load_half(input logic [2:0] t, input logic [31:0] exp);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2002; cpu_wdata = '0; cpu_dmtype = t;
    #1;
    tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL lh%0d_c1_stall got=%b exp=1", t, cpu_stall); end
    tick();
    mem_gnt = 1'b1;
    #1;
    tests++; if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'b1111, 32'h2000}) begin fails++; $display("FAIL lh%0d_req req,we,be,addr got=%h exp=%h", t, {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, 4'b1111, 32'h2000}); end
    tick();
    mem_gnt = 1'b0;
    #1;
    tests++; if ({cpu_stall, mem_req} !== 2'b10) begin fails++; $display("FAIL lh%0d_wait stall,req got=%b exp=10", t, {cpu_stall, mem_req}); end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h80011234;
    #1;
    tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL lh%0d_rvalid_stall got=%b exp=1", t, cpu_stall); end
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0; cpu_req = 1'b0;
    #1;
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL lh%0d_done_stall got=%b exp=0", t, cpu_stall); end
    tests++; if (cpu_rdata !== exp) begin fails++; $display("FAIL lh%0d_rdata got=%h exp=%h", t, cpu_rdata, exp); end
    tick();
    #1;
    tests++; if (cpu_rdata !== exp) begin fails++; $display("FAIL lh%0d_rdata_hold got=%h exp=%h", t, cpu_rdata, exp); end
    tick();
  endtask

  task automatic test_misalign();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3002; cpu_dmtype = 3'b000;
    #1;
    tests++; if ({cpu_misalign, cpu_stall, mem_req} !== 3'b100) begin fails++; $display("FAIL lw_mis misalign,stall,req got=%b exp=100", {cpu_misalign, cpu_stall, mem_req}); end
    tick();
    cpu_req = 1'b0;
    #1;
    tests++; if ({cpu_misalign, cpu_stall, mem_req} !== 3'b000) begin fails++; $display("FAIL lw_mis_after misalign,stall,req got=%b exp=000", {cpu_misalign, cpu_stall, mem_req}); end
    tests++; if (cpu_rdata !== 32'h00008001) begin fails++; $display("FAIL lw_mis_rdata got=%h exp=00008001", cpu_rdata); end
    tick();
    cpu_req = 1'b1; cpu_addr = 32'h3001; cpu_dmtype = 3'b001;
    #1;
    tests++; if ({cpu_misalign, cpu_stall} !== 2'b10) begin fails++; $display("FAIL lh_odd misalign,stall got=%b exp=10", {cpu_misalign, cpu_stall}); end
    tick();
    cpu_req = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL lh_odd_req got=%b exp=0", mem_req); end
    tick();
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h5000; cpu_dmtype = 3'b000;
    #1;
    tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL to_c1_stall got=%b exp=1", cpu_stall); end
    tick();
    for (int i = 0; i < 16; i++) begin
      #1;
      if (mem_req !== 1'b1 || cpu_stall !== 1'b1 || cpu_buserr !== 1'b0) bad++;
      tick();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL to_req_cycles bad_cycles got=%0d exp=0", bad); end
    cpu_req = 1'b0;
    #1;
    tests++; if ({cpu_buserr, cpu_stall, mem_req} !== 3'b100) begin fails++; $display("FAIL to_done buserr,stall,req got=%b exp=100", {cpu_buserr, cpu_stall, mem_req}); end
    tests++; if (cpu_rdata !== 32'h0) begin fails++; $display("FAIL to_rdata got=%h exp=0", cpu_rdata); end
    tick();
    #1;
    tests++; if ({cpu_buserr, cpu_stall, mem_req} !== 3'b000) begin fails++; $display("FAIL to_idle buserr,stall,req got=%b exp=000", {cpu_buserr, cpu_stall, mem_req}); end
    tick();
  endtask

  task automatic test_timeout_race();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h5000; cpu_dmtype = 3'b100;
    tick();
    for (int i = 0; i < 15; i++) tick();
    mem_gnt = 1'b1;
    #1;
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL race_req16 got=%b exp=1", mem_req); end
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h000000AB;
    #1;
    tests++; if ({cpu_stall, mem_req} !== 2'b10) begin fails++; $display("FAIL race_wait stall,req got=%b exp=10", {cpu_stall, mem_req}); end
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0; cpu_req = 1'b0;
    #1;
    tests++; if ({cpu_buserr, cpu_stall} !== 2'b00) begin fails++; $display("FAIL race_done buserr,stall got=%b exp=00", {cpu_buserr, cpu_stall}); end
    tests++; if (cpu_rdata !== 32'h000000AB) begin fails++; $display("FAIL race_rdata got=%h exp=000000ab", cpu_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h4000; cpu_wdata = 32'h11223344; cpu_dmtype = 3'b000;
    #1;
    tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL b2b_sw_c1_stall got=%b exp=1", cpu_stall); end
    tick();
    mem_gnt = 1'b1;
    #1;
    tests++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b1111, 32'h4000, 32'h11223344}) begin fails++; $display("FAIL b2b_sw req,we,be,addr,wdata got=%h exp=%h", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'b1111, 32'h4000, 32'h11223344}); end
    tick();
    mem_gnt = 1'b0;
    cpu_we = 1'b0; cpu_addr = 32'h4001; cpu_wdata = '0; cpu_dmtype = 3'b100;
    #1;
    tests++; if ({cpu_stall, mem_req} !== 2'b00) begin fails++; $display("FAIL b2b_done stall,req got=%b exp=00", {cpu_stall, mem_req}); end
    tick();
    #1;
    tests++; if ({cpu_stall, mem_req} !== 2'b10) begin fails++; $display("FAIL b2b_lbu_c1 stall,req got=%b exp=10", {cpu_stall, mem_req}); end
    tick();
    mem_gnt = 1'b1;
    #1;
    tests++; if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'b1111, 32'h4000}) begin fails++; $display("FAIL b2b_lbu_req req,we,be,addr got=%h exp=%h", {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, 4'b1111, 32'h4000}); end
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0; cpu_req = 1'b0;
    #1;
    tests++; if ({cpu_stall, cpu_rdata} !== {1'b0, 32'h00000033}) begin fails++; $display("FAIL b2b_lbu_done stall,rdata got=%h exp=%h", {cpu_stall, cpu_rdata}, {1'b0, 32'h00000033}); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2002; cpu_dmtype = 3'b010;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; rst = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rmw_wait_req got=%b exp=0", mem_req); end
    tick();
    rst = 1'b1; cpu_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    #1;
    tests++; if ({cpu_stall, cpu_misalign, cpu_buserr, mem_req, mem_we, mem_be} !== 9'b0) begin fails++; $display("FAIL rmw_ctl got=%b exp=0", {cpu_stall, cpu_misalign, cpu_buserr, mem_req, mem_we, mem_be}); end
    tests++; if ({cpu_rdata, mem_addr, mem_wdata} !== 96'h0) begin fails++; $display("FAIL rmw_data got=%h exp=0", {cpu_rdata, mem_addr, mem_wdata}); end
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    tests++; if ({cpu_stall, cpu_rdata} !== 33'h0) begin fails++; $display("FAIL rmw_after stall,rdata got=%h exp=0", {cpu_stall, cpu_rdata}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_store_half();
    test_load_half(3'b001, 32'hFFFF8001);
    test_load_half(3'b010, 32'h00008001);
    test_misalign();
    test_timeout();
    test_timeout_race();
    test_back_to_back();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- Data-memory access stage between the pipelined CPU's MEM-stage outputs (address, store data, DMType, mem_w/mem_r) and a variable-latency data memory port with a request/grant/rvalid handshake.
- Formats store data and byte enables per DMType.
- Extracts and extends load data.
- Stalls the pipeline until the access completes, and flags misaligned accesses and bus timeouts.

Parameters:
- WAIT_MAX, 16: maximum cycles spent in REQ or WAIT before a bus timeout is declared. Range 2..255.
- CNT_W, 8: width of the timeout counter. Must hold WAIT_MAX.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-low (asserted when 0)
- cpu_req  in  1  access request from MEM stage, held stable while cpu_stall=1
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  32  byte address (EX/MEM ALU result)
- cpu_wdata  in  32  store data (rs2 value, right-aligned)
- cpu_dmtype  in  3  access type, shared-package encoding
- cpu_rdata  out  32  formatted load data to MEM/WB
- cpu_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- cpu_misalign  out  1  one-cycle pulse: misaligned request rejected
- cpu_buserr  out  1  one-cycle pulse: timeout on the memory port
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned address, with bits [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  read data valid; earliest one cycle after gnt
- mem_rdata  in  32  raw read word

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE and timeout counter=0.
  - All outputs are 0, including cpu_rdata and all latched request registers.
  - Reset mid-operation aborts the access immediately: mem_req drops the next cycle, and any later mem_rvalid is ignored in IDLE.
- DMType encoding: word=000, half=001, half_u=010, byte=011, byte_u=100. Any other code is treated as word.
- Alignment check: half requires addr[0]=0; word requires addr[1:0]=00; bytes are always aligned.
- State IDLE:
  - cpu_req=1 and aligned: latch we/addr/wdata/dmtype, go to REQ, and assert cpu_stall combinationally in this same cycle.
  - cpu_req=1 and misaligned: cpu_misalign=1 for this cycle, no stall, no memory access, cpu_rdata unchanged, stay in IDLE.
  - cpu_req=0: stall=0.
- State REQ:
  - mem_req=1, with mem_* driven from the latched registers; stall=1.
  - On mem_gnt: a store goes to DONE, a load goes to WAIT.
- State WAIT:
  - mem_req=0, stall=1.
  - On mem_rvalid: register the formatted data into cpu_rdata, then go to DONE.
- State DONE:
  - stall=0 for exactly one cycle, so the pipeline advances.
  - Next state is IDLE. The request seen in IDLE afterwards is the next instruction's request.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle spent in REQ or WAIT.
  - When the counter reaches WAIT_MAX with no gnt or rvalid: cpu_buserr=1 in the DONE cycle, cpu_rdata=0 for a load, then go to DONE.
  - gnt or rvalid arriving in the same cycle as the timeout wins; no error is raised.
- Store formatting:
  - word: be=1111, wdata as given.
  - half: wdata={2{wdata[15:0]}}; be=0011 if addr[1]=0, else 1100.
  - byte: wdata={4{wdata[7:0]}}; be=0001<<addr[1:0].
- Load formatting:
  - Shift mem_rdata right by 8*addr[1:0].
  - half: sign-extend bit 15. half_u: zero-extend.
  - byte: sign-extend bit 7. byte_u: zero-extend.
  - mem_be=1111 on all loads.
- cpu_rdata holds its value until the next load completes or reset.
- Latency, request to stall release:
  - Store with immediate gnt: 2 cycles stalled, released in cycle 3.
  - Load with gnt in cycle 2 and rvalid in cycle 3: released in cycle 4.

Decomposition:
- Shared package `dm_pkg`:
  - DMType codes.
  - FSM state encoding (IDLE/REQ/WAIT/DONE).
  - be constants (BE_WORD, BE_HALF_LO/HI, BE_BYTE0).
- One combinational sub-module, `dm_lane_fmt`:
  - store lane/be generation.
  - load extract/extend.
- The FSM, request registers and timeout counter stay in the top module.

Test Plan:
1. sb: addr=0x1003, wdata=0x000000A5, gnt in the first REQ cycle -> mem_addr=0x1000, be=1000, mem_wdata=0xA5A5A5A5, stall high exactly 2 cycles.
2. lh: addr=0x2002, gnt cycle 2, rvalid cycle 4 with rdata=0x8001_1234 -> cpu_rdata=0xFFFF8001. Repeat as lhu -> 0x00008001.
3. lw: addr=0x3002 -> cpu_misalign pulses for 1 cycle, mem_req never asserts, stall=0, cpu_rdata unchanged.
4. Load with no gnt, WAIT_MAX=16 -> after 16 cycles in REQ, cpu_buserr=1 for 1 cycle, cpu_rdata=0, state returns to IDLE.
5. Reset mid-WAIT (rst=0 for 1 cycle), then rvalid=1 the following cycle -> all outputs 0, cpu_rdata stays 0, no stall.
6. Back-to-back sw 0x4000 then lbu 0x4001 (memory returns the stored word 0x11223344) -> be=1111 on the store, cpu_rdata=0x00000033, exactly one DONE cycle between the two accesses.
